// File: rtl/ieee_float_to_int_if.sv
// Handshake and data bundle between a float producer and the float-to-int converter.
interface ieee_float_to_int_if #(
  parameter int INT_WIDTH = 32
) ();
  logic                 start_in;
  logic [31:0]          number_in;
  logic                 busy_out;
  logic                 done_out;
  logic [INT_WIDTH-1:0] result_out;
  logic                 overflow_out;
  logic                 invalid_out;

  modport master (
    output start_in, number_in,
    input  busy_out, done_out, result_out, overflow_out, invalid_out
  );

  modport slave (
    input  start_in, number_in,
    output busy_out, done_out, result_out, overflow_out, invalid_out
  );
endinterface

// File: rtl/ieee_float_to_int.sv
// Iterative IEEE 754 single -> signed integer converter, truncating toward zero.
// One shift per cycle; saturates on overflow/Inf and flags NaN.
//
// state  | meaning
// IDLE   | waiting for start_in; operand latched on accept
// DECODE | classify operand, load accumulator and shift count
// SHIFT  | one bit per cycle until the count reaches zero, then publish result
// FINISH | done_out pulse cycle; start_in ignored here
module ieee_float_to_int #(
  parameter int INT_WIDTH = 32
) (
  input logic             clock_in,
  input logic             reset_n,
  ieee_float_to_int_if.slave bus
);

  localparam int ACC_W = (INT_WIDTH > 24) ? INT_WIDTH : 24;
  localparam logic signed [9:0] EXP_LIM = 10'(INT_WIDTH - 1);
  localparam logic [INT_WIDTH-1:0] MAX_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] MIN_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]           state;
  logic [31:0]          numReg;
  logic [ACC_W-1:0]     acc;
  logic [5:0]           shiftCnt;
  logic                 shiftLeft;
  logic                 useFixed;
  logic [INT_WIDTH-1:0] fixedVal;
  logic                 ovfPend;
  logic                 invPend;

  logic                 busyReg;
  logic                 doneReg;
  logic [INT_WIDTH-1:0] resultReg;
  logic                 ovfReg;
  logic                 invReg;

  logic                 signBit;
  logic [7:0]           expField;
  logic [22:0]          fracField;
  logic signed [9:0]    expUnb;
  logic [5:0]           shiftAmt;
  logic [INT_WIDTH-1:0] accLow;
  logic [INT_WIDTH-1:0] accNeg;

  assign signBit   = numReg[31];
  assign expField  = numReg[30:23];
  assign fracField = numReg[22:0];
  assign expUnb    = $signed({2'b00, expField}) - 10'sd127;
  // Only evaluated on the normal path, where expUnb lies in 0..INT_WIDTH-2.
  assign shiftAmt  = (expUnb > 10'sd23) ? 6'(expUnb - 10'sd23) : 6'(10'sd23 - expUnb);
  assign accLow    = acc[INT_WIDTH-1:0];
  assign accNeg    = '0 - accLow;

  assign bus.busy_out     = busyReg;
  assign bus.done_out     = doneReg;
  assign bus.result_out   = resultReg;
  assign bus.overflow_out = ovfReg;
  assign bus.invalid_out  = invReg;

  // Sequencer: latch, classify, shift to alignment, publish result with a one-cycle done pulse.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      numReg    <= '0;
      acc       <= '0;
      shiftCnt  <= '0;
      shiftLeft <= 1'b0;
      useFixed  <= 1'b0;
      fixedVal  <= '0;
      ovfPend   <= 1'b0;
      invPend   <= 1'b0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      resultReg <= '0;
      ovfReg    <= 1'b0;
      invReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            numReg  <= bus.number_in;
            busyReg <= 1'b1;
            state   <= DECODE;
          end
        end

        DECODE: begin
          ovfPend  <= 1'b0;
          invPend  <= 1'b0;
          useFixed <= 1'b1;
          fixedVal <= '0;
          shiftCnt <= '0;
          if (expField == 8'hFF) begin
            if (fracField != '0) begin
              invPend <= 1'b1;
            end else begin
              ovfPend  <= 1'b1;
              fixedVal <= signBit ? MIN_NEG : MAX_POS;
            end
          end else if (expField == 8'h00 || expUnb < 10'sd0) begin
            fixedVal <= '0;
          end else if (expUnb >= EXP_LIM) begin
            // -2^(W-1) is representable exactly; every other value here is out of range.
            fixedVal <= signBit ? MIN_NEG : MAX_POS;
            ovfPend  <= !(signBit && expUnb == EXP_LIM && fracField == '0);
          end else begin
            useFixed  <= 1'b0;
            acc       <= ACC_W'({1'b1, fracField});
            shiftCnt  <= shiftAmt;
            shiftLeft <= (expUnb > 10'sd23);
          end
          state <= SHIFT;
        end

        SHIFT: begin
          if (shiftCnt == 6'd0) begin
            resultReg <= useFixed ? fixedVal : (signBit ? accNeg : accLow);
            ovfReg    <= ovfPend;
            invReg    <= invPend;
            doneReg   <= 1'b1;
            state     <= FINISH;
          end else begin
            acc      <= shiftLeft ? (acc << 1) : (acc >> 1);
            shiftCnt <= shiftCnt - 6'd1;
          end
        end

        FINISH: begin
          doneReg <= 1'b0;
          busyReg <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee_float_to_int.sv
// Self-checking bench for ieee_float_to_int: directed vectors, randomized operands
// against a magnitude-based reference model, busy/back-to-back handshake and reset abort.
module tb_ieee_float_to_int;
  localparam int W = 32;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;

  ieee_float_to_int_if #(.INT_WIDTH(W)) bus ();

  ieee_float_to_int #(.INT_WIDTH(W)) dut (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock_in = ~clock_in;

  // Reference: exact truncated magnitude, then range check as a C cast with saturation.
  function automatic void ref_model(input logic [31:0] f, output logic [31:0] res,
                                    output logic ovf, output logic inv, output int lat);
    int e;
    int ex;
    logic [127:0] mag;
    e = int'(f[30:23]);
    res = '0; ovf = 1'b0; inv = 1'b0; lat = 2;
    if (e == 255) begin
      if (f[22:0] != 23'd0) inv = 1'b1;
      else begin ovf = 1'b1; res = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; end
    end else if (e == 0 || e < 127) begin
      res = '0;
    end else begin
      ex  = e - 127;
      mag = 128'({1'b1, f[22:0]});
      if (ex >= 23) mag = mag << (ex - 23);
      else          mag = mag >> (23 - ex);
      if (!f[31] && mag > 128'h7FFF_FFFF) begin
        ovf = 1'b1; res = 32'h7FFF_FFFF;
      end else if (f[31] && mag > 128'h8000_0000) begin
        ovf = 1'b1; res = 32'h8000_0000;
      end else begin
        res = f[31] ? 32'(128'd0 - mag) : mag[31:0];
      end
      if (ex < W - 1) lat = 2 + ((ex >= 23) ? (ex - 23) : (23 - ex));
    end
  endfunction

  // Issue one start in IDLE and wait (bounded) for done; latency counted from the accepting edge.
  task automatic run_conv(input logic [31:0] num, output logic [31:0] res, output logic ovf,
                          output logic inv, output int lat, output logic gotDone,
                          output logic busyAtDone);
    @(negedge clock_in);
    bus.start_in  = 1'b1;
    bus.number_in = num;
    @(posedge clock_in);
    #1;
    bus.start_in  = 1'b0;
    bus.number_in = $urandom;
    gotDone = 1'b0; lat = 0; res = '0; ovf = 1'b0; inv = 1'b0; busyAtDone = 1'b0;
    for (int k = 1; k <= 80 && !gotDone; k++) begin
      @(posedge clock_in);
      #1;
      if (bus.done_out === 1'b1) begin
        gotDone = 1'b1; lat = k; res = bus.result_out;
        ovf = bus.overflow_out; inv = bus.invalid_out; busyAtDone = bus.busy_out;
      end
    end
  endtask

  task automatic test_reset();
    bus.start_in  = 1'b0;
    bus.number_in = '0;
    reset_n = 1'b0;
    #12;
    checkCount++;
    if ({bus.busy_out, bus.done_out, bus.overflow_out, bus.invalid_out} !== 4'b0000) begin
      $display("FAIL reset_flags: got busy/done/ovf/inv=%b expected 0000",
               {bus.busy_out, bus.done_out, bus.overflow_out, bus.invalid_out});
    end else passCount++;
    checkCount++;
    if (bus.result_out !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", bus.result_out);
    else passCount++;
    @(negedge clock_in);
    reset_n = 1'b1;
    repeat (2) @(negedge clock_in);
    checkCount++;
    if (bus.busy_out !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy_out);
    else passCount++;
  endtask

  task automatic test_directed();
    logic [31:0] vNum [0:13] = '{32'h3F80_0000, 32'hC2F6_E979, 32'h3F00_0000, 32'h4F00_0000,
                                 32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001,
                                 32'h4120_0000, 32'h4EFF_FFFF, 32'hCF00_0001, 32'h7F80_0000,
                                 32'h8000_0000, 32'hBF80_0000};
    logic [31:0] vRes [0:13] = '{32'h0000_0001, 32'hFFFF_FF85, 32'h0, 32'h7FFF_FFFF,
                                 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0,
                                 32'h0000_000A, 32'h7FFF_FF80, 32'h8000_0000, 32'h7FFF_FFFF,
                                 32'h0, 32'hFFFF_FFFF};
    logic        vOvf [0:13] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    logic        vInv [0:13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    int          vLat [0:13] = '{25, 19, 2, 2, 2, 2, 2, 2, 22, 9, 2, 2, 2, 25};
    logic [31:0] res;
    logic ovf, inv, got, bsy;
    int lat;
    for (int i = 0; i < 14; i++) begin
      run_conv(vNum[i], res, ovf, inv, lat, got, bsy);
      checkCount++;
      if (got !== 1'b1) $display("FAIL dir_timeout[%0d]: no done for %h within 80 cycles", i, vNum[i]);
      else passCount++;
      checkCount++;
      if ({res, ovf, inv} !== {vRes[i], vOvf[i], vInv[i]})
        $display("FAIL dir_value[%0d] in=%h: got res=%h ovf=%b inv=%b expected res=%h ovf=%b inv=%b",
                 i, vNum[i], res, ovf, inv, vRes[i], vOvf[i], vInv[i]);
      else passCount++;
      checkCount++;
      if (lat !== vLat[i] || bsy !== 1'b1)
        $display("FAIL dir_latency[%0d] in=%h: got lat=%0d busy=%b expected lat=%0d busy=1",
                 i, vNum[i], lat, bsy, vLat[i]);
      else passCount++;
      @(posedge clock_in);
      #1;
      checkCount++;
      if ({bus.done_out, bus.busy_out} !== 2'b00)
        $display("FAIL dir_pulse[%0d]: got done/busy=%b%b after pulse expected 00", i,
                 bus.done_out, bus.busy_out);
      else passCount++;
      checkCount++;
      if ({bus.result_out, bus.overflow_out, bus.invalid_out} !== {vRes[i], vOvf[i], vInv[i]})
        $display("FAIL dir_hold[%0d]: got res=%h expected %h held", i, bus.result_out, vRes[i]);
      else passCount++;
    end
  endtask

  task automatic test_random();
    logic [31:0] num, res, eRes;
    logic ovf, inv, got, bsy, eOvf, eInv;
    int lat, eLat, sel;
    logic [7:0] ex;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ex = 8'd255;
        1:       ex = 8'd0;
        2:       ex = 8'($urandom_range(100, 126));
        default: ex = 8'($urandom_range(127, 160));
      endcase
      num = {1'($urandom), ex, 23'($urandom)};
      if (sel == 0 && $urandom_range(0, 1) == 0) num[22:0] = '0;
      ref_model(num, eRes, eOvf, eInv, eLat);
      run_conv(num, res, ovf, inv, lat, got, bsy);
      checkCount++;
      if (got !== 1'b1 || lat !== eLat)
        $display("FAIL rnd_latency in=%h: got done=%b lat=%0d expected done=1 lat=%0d", num, got, lat, eLat);
      else passCount++;
      checkCount++;
      if ({res, ovf, inv} !== {eRes, eOvf, eInv})
        $display("FAIL rnd_value in=%h: got res=%h ovf=%b inv=%b expected res=%h ovf=%b inv=%b",
                 num, res, ovf, inv, eRes, eOvf, eInv);
      else passCount++;
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] first, eRes;
    logic eOvf, eInv;
    int eLat, dones, extra, lat;
    logic busyDrop;
    logic [31:0] res;
    first = {1'b1, 8'd133, 23'($urandom)};
    ref_model(first, eRes, eOvf, eInv, eLat);
    @(negedge clock_in);
    bus.start_in  = 1'b1;
    bus.number_in = first;
    @(posedge clock_in);
    #1;
    dones = 0; busyDrop = 1'b0; lat = 0; res = '0;
    for (int k = 1; k <= 80 && dones == 0; k++) begin
      @(negedge clock_in);
      bus.number_in = $urandom;
      @(posedge clock_in);
      #1;
      if (bus.busy_out !== 1'b1) busyDrop = 1'b1;
      if (bus.done_out === 1'b1) begin dones++; lat = k; res = bus.result_out; end
    end
    @(negedge clock_in);
    bus.start_in = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clock_in);
      #1;
      if (bus.done_out === 1'b1 || bus.busy_out === 1'b1) extra++;
    end
    checkCount++;
    if (dones !== 1 || lat !== eLat || busyDrop !== 1'b0)
      $display("FAIL busy_first: got dones=%0d lat=%0d busyDrop=%b expected 1 %0d 0", dones, lat, busyDrop, eLat);
    else passCount++;
    checkCount++;
    if (res !== eRes) $display("FAIL busy_value: got %h expected %h", res, eRes);
    else passCount++;
    checkCount++;
    if (extra !== 0) $display("FAIL busy_requeue: got %0d extra busy/done cycles expected 0", extra);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] num, res, eRes;
    logic ovf, inv, got, bsy, eOvf, eInv;
    int lat, eLat;
    for (int i = 0; i < 6; i++) begin
      num = {1'($urandom), 8'($urandom_range(120, 158)), 23'($urandom)};
      ref_model(num, eRes, eOvf, eInv, eLat);
      run_conv(num, res, ovf, inv, lat, got, bsy);
      checkCount++;
      if (got !== 1'b1 || lat !== eLat || {res, ovf, inv} !== {eRes, eOvf, eInv})
        $display("FAIL b2b[%0d] in=%h: got done=%b lat=%0d res=%h ovf=%b inv=%b expected lat=%0d res=%h ovf=%b inv=%b",
                 i, num, got, lat, res, ovf, inv, eLat, eRes, eOvf, eInv);
      else passCount++;
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    logic ovf, inv, got, bsy;
    int lat, dones;
    run_conv(32'h4120_0000, res, ovf, inv, lat, got, bsy);
    @(posedge clock_in);
    #1;
    checkCount++;
    if (bus.result_out !== 32'd10) $display("FAIL abort_pre: got %h expected 0000000a", bus.result_out);
    else passCount++;
    @(negedge clock_in);
    bus.start_in  = 1'b1;
    bus.number_in = 32'h3F80_0000;
    @(posedge clock_in);
    #1;
    bus.start_in = 1'b0;
    repeat (6) @(posedge clock_in);
    #2;
    reset_n = 1'b0;
    #1;
    checkCount++;
    if ({bus.busy_out, bus.done_out, bus.overflow_out, bus.invalid_out, bus.result_out} !== 36'h0)
      $display("FAIL abort_clear: got busy=%b done=%b ovf=%b inv=%b res=%h expected all 0",
               bus.busy_out, bus.done_out, bus.overflow_out, bus.invalid_out, bus.result_out);
    else passCount++;
    @(negedge clock_in);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clock_in);
      #1;
      if (bus.done_out === 1'b1 || bus.busy_out === 1'b1) dones++;
    end
    checkCount++;
    if (dones !== 0) $display("FAIL abort_nodone: got %0d busy/done cycles expected 0", dones);
    else passCount++;
    run_conv(32'h4120_0000, res, ovf, inv, lat, got, bsy);
    checkCount++;
    if (got !== 1'b1 || res !== 32'd10 || {ovf, inv} !== 2'b00 || lat !== 22)
      $display("FAIL abort_next: got done=%b res=%h ovf=%b inv=%b lat=%0d expected 1 0000000a 0 0 22",
               got, res, ovf, inv, lat);
    else passCount++;
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
